sprite_table_regs: RTL

- Avalon-MM slave between the HPS/Nios bus and sprite_controller. It owns the sprite entry table that drives sprite_controller's gl_array input.
- The CPU writes entries into a shadow bank. On commit, the block copies the shadow bank into the active bank at the start of the next vertical blank.
- This gives tear-free sprite updates: gl_array changes only while no visible line is being scanned.

---
 rtl/sprite_table_regs.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sprite_table_regs.sv
`default_nettype none
// ============================================================================
// Module  : sprite_table_regs
// Purpose : Avalon-MM sprite table with CPU-side shadow bank and a display-side
//           active bank that is refreshed atomically at the start of vblank.
// Rev     : 1.0
// ============================================================================
module sprite_table_regs #(
    parameter int NUM_SPRITES = 20,
    parameter int ENTRY_W     = 24,
    parameter int VBLANK_LINE = 480
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           chipselect,
    input  logic                           write,
    input  logic                           read,
    input  logic [4:0]                     address,
    input  logic [31:0]                    writedata,
    output logic [31:0]                    readdata,
    output logic                           waitrequest,
    input  logic [9:0]                     hcount,
    input  logic [9:0]                     vcount,
    output logic [NUM_SPRITES*ENTRY_W-1:0] gl_array,
    output logic                           frame_irq
);

    localparam int                 c_idx_w       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [4:0]         c_addr_ctrl   = 5'(NUM_SPRITES);
    localparam logic [4:0]         c_addr_status = 5'(NUM_SPRITES + 1);
    localparam logic [4:0]         c_addr_frame  = 5'(NUM_SPRITES + 2);
    localparam logic [c_idx_w-1:0] c_last_idx    = c_idx_w'(NUM_SPRITES - 1);
    localparam logic [c_idx_w-1:0] c_idx_one     = c_idx_w'(1);
    localparam logic [9:0]         c_vblank_line = 10'(VBLANK_LINE);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_copy = 1'b1;

    logic [ENTRY_W-1:0] r_shadow [NUM_SPRITES];
    logic [ENTRY_W-1:0] r_active [NUM_SPRITES];
    logic [0:0]         r_state;
    logic [c_idx_w-1:0] r_idx;
    logic               r_pending;
    logic               r_cmp;
    logic               r_vb_start;
    logic               r_irq;
    logic [15:0]        r_frame;
    logic [31:0]        r_readdata;

    logic               w_copying;
    logic               w_wait;
    logic               w_wr;
    logic               w_rd;
    logic               w_start;
    logic               w_cmp;
    logic               w_ctrl_wr;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_copying = (r_state == c_st_copy);
    // Only writes that could disturb the snapshot (shadow entries, CTRL) stall.
    assign w_wait    = w_copying & chipselect & write & (address <= c_addr_ctrl);
    assign w_wr      = chipselect & write & ~w_wait;
    assign w_rd      = chipselect & read & ~write & ~w_wait;
    assign w_ctrl_wr = w_wr & (address == c_addr_ctrl);
    assign w_start   = (r_state == c_st_idle) & r_vb_start & r_pending;
    assign w_cmp     = (vcount == c_vblank_line);
    assign w_unused  = ^{hcount, writedata[31:ENTRY_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) r_shadow[i] <= '0;
        end else if (w_wr) begin
            if (address < c_addr_ctrl) begin
                r_shadow[address] <= writedata[ENTRY_W-1:0];
            end else if (w_ctrl_wr && writedata[1]) begin
                for (int i = 0; i < NUM_SPRITES; i++) r_shadow[i] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) r_active[i] <= '0;
        end else if (w_copying) begin
            r_active[r_idx] <= r_shadow[r_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_idx   <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_state <= c_st_copy;
                        r_idx   <= '0;
                    end
                end
                c_st_copy: begin
                    if (r_idx == c_last_idx) begin
                        r_state <= c_st_idle;
                        r_irq   <= 1'b1;
                    end else begin
                        r_idx <= r_idx + c_idx_one;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // A commit arriving in the same cycle a copy launches is kept for next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (w_ctrl_wr && writedata[0]) begin
            r_pending <= 1'b1;
        end else if (w_start) begin
            r_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmp      <= 1'b0;
            r_vb_start <= 1'b0;
            r_frame    <= '0;
        end else begin
            r_cmp      <= w_cmp;
            r_vb_start <= w_cmp & ~r_cmp;
            if (r_vb_start) begin
                r_frame <= r_frame + 16'd1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (address < c_addr_ctrl) begin
            w_rdata[ENTRY_W-1:0] = r_shadow[address];
        end else if (address == c_addr_status) begin
            w_rdata[1:0] = {w_copying, r_pending};
        end else if (address == c_addr_frame) begin
            w_rdata[15:0] = r_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rdata;
        end
    end

    generate
        for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_gl
            assign gl_array[g*ENTRY_W +: ENTRY_W] = r_active[g];
        end
    endgenerate

    assign readdata    = r_readdata;
    assign waitrequest = w_wait;
    assign frame_irq   = r_irq;

endmodule
`default_nettype wire
